irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Interrupt controller directly upstream of the pipelined CPU core: conditions the 4 external INTERRUPT lines
//  and presents one prioritised request plus vector to the fetch stage.
//  Fetch takes the vector (acks); write-back reports the retirement of return-from-interrupt (ends service).
//  Single-level, non-nesting; one interrupt in service at a time.
// PARAMETERS
//  VEC_BASE     16'h0100  vector address of line 0
//  VEC_STRIDE   16'h0010  address step between consecutive line vectors
//  SYNC_STAGES  2         synchroniser flops per IRQ line (legal 2..3)
// PORTS
//  CLK          in   1   system clock; all state updates on rising edge
//  RST          in   1   synchronous reset, active-low
//  INTERRUPT    in   4   async external IRQ lines, rising-edge sensitive
//  EN_WE        in   1   write strobe for the enable register
//  EN_IN        in   4   new enable mask, bit i enables line i
//  INT_ACK      in   1   fetch stage has redirected to INT_VECTOR
//  INT_RET      in   1   WB stage retired return-from-interrupt
//  INT_REQ      out  1   request to fetch stage
//  INT_VECTOR   out  16  target address = VEC_BASE + INT_ID*VEC_STRIDE (16-bit, wraps mod 2^16)
//  INT_ID       out  2   line being requested / serviced
//  IN_SERVICE   out  1   handler is running
//  PENDING      out  4   latched, not-yet-acked edges (before masking)
//  ENABLE       out  4   current enable register
// BEHAVIOUR
//  Reset (RST==0 at a clock edge): INT_REQ=0, INT_VECTOR=0, INT_ID=0, IN_SERVICE=0, PENDING=0, ENABLE=0,
//   synchroniser and edge-history flops=0, FSM=IDLE.
//   Reset mid-request/mid-service: everything is discarded; no ack/ret is required afterwards.
//  Sync/edge: each line passes SYNC_STAGES flops; edge = sync_out & ~prev.
//   A line already high at reset release produces one edge.
//  Latency (SYNC_STAGES=2): INTERRUPT first sampled high at edge k -> PENDING[i]=1 after edge k+3 ->
//   INT_REQ=1 after edge k+4 (if IDLE and enabled).
//  PENDING[i]: set on edge; cleared only by INT_ACK for line i. Set beats clear in the same cycle.
//   Repeated edges while pending collapse to one.
//  Masked lines still latch PENDING; they request only once enabled.
//   EN_WE takes effect next cycle (ENABLE <= EN_IN).
//  Priority: eligible = PENDING & ENABLE; lowest index wins (line 0 highest).
//  FSM:
//   IDLE: if eligible!=0 -> REQ; latch INT_ID=winner and INT_VECTOR; INT_REQ=1.
//   REQ: INT_REQ=1; INT_ID/INT_VECTOR held stable (no preemption by higher priority, unaffected by EN_WE).
//    INT_ACK -> SERVICE: INT_REQ=0, IN_SERVICE=1, clear PENDING[INT_ID].
//   SERVICE: INT_RET -> IDLE, IN_SERVICE=0. New edges keep latching.
//    Earliest next INT_REQ is the cycle after return to IDLE.
//  Ignored inputs: INT_ACK outside REQ; INT_RET outside SERVICE.
//   INT_ACK and INT_RET in the same cycle: only the one legal for the current state acts.
//  INT_VECTOR/INT_ID keep their last values in IDLE; meaningful only while INT_REQ or IN_SERVICE.
// TESTING
//  T1 reset: hold RST=0 3 cycles with INTERRUPT=4'hF -> all outputs 0.
//   Release with ENABLE=0 -> PENDING=4'hF, INT_REQ stays 0.
//  T2 basic: ENABLE=4'hF, pulse INTERRUPT[2] -> INT_REQ=1 4 cycles later, INT_ID=2, INT_VECTOR=16'h0120.
//   INT_ACK -> IN_SERVICE=1, PENDING[2]=0. INT_RET -> IDLE.
//  T3 priority/no preempt: edges on lines 3 and 1 together -> INT_ID=1 (vec 16'h0110).
//   Line 0 edge during REQ -> INT_ID stays 1. After ack+ret -> line 0 then line 3 serviced.
//  T4 mask: ENABLE=4'b0111, edge on line 3 -> no INT_REQ, PENDING[3]=1.
//   Write ENABLE=4'hF -> INT_REQ, INT_ID=3, vec 16'h0130.
//  T5 collisions: new line-2 edge in the INT_ACK cycle for line 2 -> PENDING[2] stays 1.
//   Second request follows the INT_RET. Stray INT_ACK/INT_RET in IDLE -> no change.
//  T6 reset mid-service: RST=0 while IN_SERVICE=1 -> IN_SERVICE=0, PENDING=0 next cycle, FSM IDLE.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: conditions four asynchronous rising-edge interrupt lines and presents
// one prioritised, non-nesting request plus vector address to the fetch stage.
//
// Ports
//   CLK         system clock, all state updates on the rising edge
//   RST         synchronous reset, active-low
//   INTERRUPT   asynchronous external IRQ lines (rising-edge sensitive)
//   EN_WE       write strobe for the enable register
//   EN_IN       new enable mask, bit i enables line i
//   INT_ACK     fetch stage has redirected to INT_VECTOR
//   INT_RET     write-back retired return-from-interrupt
//   INT_REQ     request to the fetch stage
//   INT_VECTOR  VEC_BASE + INT_ID*VEC_STRIDE (wraps mod 2^16)
//   INT_ID      line being requested / serviced
//   IN_SERVICE  handler is running
//   PENDING     latched, not-yet-acked edges (before masking)
//   ENABLE      current enable register
module irq_ctrl #(
  parameter logic [15:0] VEC_BASE    = 16'h0100,
  parameter logic [15:0] VEC_STRIDE  = 16'h0010,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  INTERRUPT,
  input  logic        EN_WE,
  input  logic [3:0]  EN_IN,
  input  logic        INT_ACK,
  input  logic        INT_RET,
  output logic        INT_REQ,
  output logic [15:0] INT_VECTOR,
  output logic [1:0]  INT_ID,
  output logic        IN_SERVICE,
  output logic [3:0]  PENDING,
  output logic [3:0]  ENABLE
);

  localparam int unsigned NUM_LINES = 4;
  localparam int unsigned ID_W      = 2;
  localparam int unsigned VEC_W     = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [NUM_LINES-1:0] sync_q [SYNC_STAGES];
  logic [NUM_LINES-1:0] sync_out;
  logic [NUM_LINES-1:0] prev_q;
  logic [NUM_LINES-1:0] edge_q;

  logic [NUM_LINES-1:0] eligible;
  logic [ID_W-1:0]      winner;
  logic [NUM_LINES-1:0] ack_clr;
  logic [NUM_LINES-1:0] pending_d;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             req_d;
  logic             svc_d;
  logic [ID_W-1:0]  id_d;
  logic [VEC_W-1:0] vec_d;

  // Synchroniser chain; all stages cleared so a line high at release yields one edge
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= INTERRUPT;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Rising-edge detect, registered once more before it reaches PENDING
  always_ff @(posedge CLK) begin
    if (!RST) begin
      prev_q <= '0;
      edge_q <= '0;
    end else begin
      prev_q <= sync_out;
      edge_q <= sync_out & ~prev_q;
    end
  end

  // Fixed priority: lowest-numbered eligible line wins
  always_comb begin
    eligible = PENDING & ENABLE;
    winner   = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = ID_W'(i);
      end
    end
  end

  // Next-state and next-output logic; ID/vector are frozen outside IDLE
  always_comb begin
    state_d = state_q;
    req_d   = INT_REQ;
    svc_d   = IN_SERVICE;
    id_d    = INT_ID;
    vec_d   = INT_VECTOR;
    ack_clr = '0;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          id_d    = winner;
          vec_d   = VEC_BASE + VEC_W'(winner) * VEC_STRIDE;
        end
      end
      ST_REQ: begin
        if (INT_ACK) begin
          state_d         = ST_SERVICE;
          req_d           = 1'b0;
          svc_d           = 1'b1;
          ack_clr[INT_ID] = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (INT_RET) begin
          state_d = ST_IDLE;
          svc_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        svc_d   = 1'b0;
      end
    endcase
  end

  // A new edge in the ack cycle wins over the clear
  assign pending_d = (PENDING & ~ack_clr) | edge_q;

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      INT_REQ    <= 1'b0;
      IN_SERVICE <= 1'b0;
      INT_ID     <= '0;
      INT_VECTOR <= '0;
      PENDING    <= '0;
      ENABLE     <= '0;
    end else begin
      state_q    <= state_d;
      INT_REQ    <= req_d;
      IN_SERVICE <= svc_d;
      INT_ID     <= id_d;
      INT_VECTOR <= vec_d;
      PENDING    <= pending_d;
      if (EN_WE) begin
        ENABLE <= EN_IN;
      end
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios followed by randomized traffic for irq_ctrl,
// each cycle compared against a behavioural reference model.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  intr;
  logic        en_we;
  logic [3:0]  en_in;
  logic        ack;
  logic        ret;
  logic        int_req;
  logic [15:0] int_vector;
  logic [1:0]  int_id;
  logic        in_service;
  logic [3:0]  pending;
  logic [3:0]  enable;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic        m_req;
  logic        m_insvc;
  logic [1:0]  m_id;
  logic [15:0] m_vec;
  logic [3:0]  m_pend;
  logic [3:0]  m_en;
  int          m_mode;          // 0 idle, 1 requesting, 2 in service
  logic [3:0]  hist [1:4];      // hist[j] = INTERRUPT as sampled j edges ago

  always #5 clk = ~clk;

  irq_ctrl dut (
    .CLK        (clk),
    .RST        (rst),
    .INTERRUPT  (intr),
    .EN_WE      (en_we),
    .EN_IN      (en_in),
    .INT_ACK    (ack),
    .INT_RET    (ret),
    .INT_REQ    (int_req),
    .INT_VECTOR (int_vector),
    .INT_ID     (int_id),
    .IN_SERVICE (in_service),
    .PENDING    (pending),
    .ENABLE     (enable)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] first_set(input logic [3:0] v);
    logic found;
    first_set = 2'd0;
    found     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (v[i] && !found) begin
        first_set = 2'(i);
        found     = 1'b1;
      end
    end
  endfunction

  // One rising edge of the behavioural model, using the inputs driven for that edge
  task automatic model_step();
    logic [3:0] new_edges;
    logic [3:0] elig;
    logic [3:0] clr;
    if (!rst) begin
      m_req = 1'b0; m_insvc = 1'b0; m_id = 2'd0; m_vec = 16'h0000;
      m_pend = 4'h0; m_en = 4'h0; m_mode = 0;
      for (int j = 1; j <= 4; j++) hist[j] = 4'h0;
    end else begin
      // A line sampled high three edges ago after being low four edges ago latches now
      new_edges = hist[3] & ~hist[4];
      elig      = m_pend & m_en;
      clr       = 4'h0;
      if (m_mode == 0) begin
        if (elig != 4'h0) begin
          m_id   = first_set(elig);
          m_vec  = 16'h0100 + 16'(m_id) * 16'h0010;
          m_req  = 1'b1;
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (ack) begin
          m_req   = 1'b0;
          m_insvc = 1'b1;
          clr     = 4'h1 << m_id;
          m_mode  = 2;
        end
      end else begin
        if (ret) begin
          m_insvc = 1'b0;
          m_mode  = 0;
        end
      end
      m_pend = (m_pend & ~clr) | new_edges;
      if (en_we) m_en = en_in;
      hist[4] = hist[3];
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = intr;
    end
  endtask

  task automatic check_all();
    check("req",     16'(int_req),    16'(m_req));
    check("insvc",   16'(in_service), 16'(m_insvc));
    check("id",      16'(int_id),     16'(m_id));
    check("vector",  int_vector,      m_vec);
    check("pending", 16'(pending),    16'(m_pend));
    check("enable",  16'(enable),     16'(m_en));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic wait_req(input int budget);
    int n;
    n = 0;
    while (!int_req && n < budget) begin
      tick();
      n++;
    end
    check("req_timeout", 16'(int_req), 16'h0001);
  endtask

  task automatic ack_ret();
    ack = 1'b1; tick(); ack = 1'b0;
    check("svc_after_ack", 16'(in_service), 16'h0001);
    ret = 1'b1; tick(); ret = 1'b0;
    check("idle_after_ret", 16'(in_service), 16'h0000);
  endtask

  initial begin
    rst = 1'b0; intr = 4'h0; en_we = 1'b0; en_in = 4'h0; ack = 1'b0; ret = 1'b0;
    m_req = 1'b0; m_insvc = 1'b0; m_id = 2'd0; m_vec = 16'h0000;
    m_pend = 4'h0; m_en = 4'h0; m_mode = 0;
    for (int j = 1; j <= 4; j++) hist[j] = 4'h0;

    // T1: reset with all lines high, then release with lines masked
    intr = 4'hF;
    repeat (3) tick();
    check("t1_rst_pend", 16'(pending), 16'h0000);
    check("t1_rst_vec",  int_vector,   16'h0000);
    rst = 1'b1;
    repeat (4) tick();
    check("t1_pend_all", 16'(pending), 16'h000F);
    check("t1_no_req",   16'(int_req), 16'h0000);
    intr = 4'h0; rst = 1'b0; tick(); rst = 1'b1; tick();

    // T2: single edge on line 2, exact latency
    en_we = 1'b1; en_in = 4'hF; tick(); en_we = 1'b0;
    intr = 4'b0100; tick(); intr = 4'h0;
    repeat (3) tick();
    check("t2_pend",    16'(pending), 16'h0004);
    check("t2_req_lat", 16'(int_req), 16'h0000);
    tick();
    check("t2_req", 16'(int_req), 16'h0001);
    check("t2_id",  16'(int_id),  16'h0002);
    check("t2_vec", int_vector,   16'h0120);
    ack = 1'b1; tick(); ack = 1'b0;
    check("t2_svc",     16'(in_service), 16'h0001);
    check("t2_pend_cl", 16'(pending),    16'h0000);
    ret = 1'b1; tick(); ret = 1'b0;
    check("t2_ret", 16'(in_service), 16'h0000);

    // T3: priority and no preemption
    intr = 4'b1010; tick(); intr = 4'h0;
    wait_req(10);
    check("t3_id",  16'(int_id), 16'h0001);
    check("t3_vec", int_vector,  16'h0110);
    intr = 4'b0001; tick(); intr = 4'h0;
    repeat (5) tick();
    check("t3_no_preempt", 16'(int_id),  16'h0001);
    check("t3_pend",       16'(pending), 16'h000B);
    ack_ret();
    wait_req(10);
    check("t3_second", 16'(int_id), 16'h0000);
    ack_ret();
    wait_req(10);
    check("t3_third", 16'(int_id), 16'h0003);
    ack_ret();

    // T4: masked line latches but requests only once enabled
    en_we = 1'b1; en_in = 4'b0111; tick(); en_we = 1'b0;
    intr = 4'b1000; tick(); intr = 4'h0;
    repeat (6) tick();
    check("t4_masked", 16'(int_req), 16'h0000);
    check("t4_pend",   16'(pending), 16'h0008);
    en_we = 1'b1; en_in = 4'hF; tick(); en_we = 1'b0;
    wait_req(5);
    check("t4_id",  16'(int_id), 16'h0003);
    check("t4_vec", int_vector,  16'h0130);
    ack_ret();

    // T5: edge arriving in the ack cycle survives the clear
    intr = 4'b0100; tick(); intr = 4'h0;
    wait_req(10);
    intr = 4'b0100; tick(); intr = 4'h0;
    tick(); tick();
    ack = 1'b1; tick(); ack = 1'b0;
    check("t5_set_wins", 16'(pending),    16'h0004);
    check("t5_svc",      16'(in_service), 16'h0001);
    ret = 1'b1; tick(); ret = 1'b0;
    wait_req(3);
    check("t5_again", 16'(int_id), 16'h0002);
    ack_ret();
    ack = 1'b1; ret = 1'b1; tick(); ack = 1'b0; ret = 1'b0;
    check("t5_stray_req", 16'(int_req),    16'h0000);
    check("t5_stray_svc", 16'(in_service), 16'h0000);

    // T6: reset while in service
    intr = 4'b0010; tick(); intr = 4'h0;
    wait_req(10);
    ack = 1'b1; tick(); ack = 1'b0;
    check("t6_svc", 16'(in_service), 16'h0001);
    rst = 1'b0; tick(); rst = 1'b1;
    check("t6_svc_clr",  16'(in_service), 16'h0000);
    check("t6_pend_clr", 16'(pending),    16'h0000);
    check("t6_en_clr",   16'(enable),     16'h0000);

    // Randomized traffic against the model
    en_we = 1'b1; en_in = 4'hF; tick(); en_we = 1'b0;
    repeat (800) begin
      if ($urandom_range(0, 3) == 0) intr = 4'($urandom);
      en_we = ($urandom_range(0, 15) == 0);
      en_in = 4'($urandom);
      ack   = int_req    ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      ret   = in_service ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 149) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
